// File: rtl/phy_tx_serializer_pkg.sv
// Package phy_tx_pkg: shared constants and helpers for the PHY transmit path.
//   - FSM state encoding (IDLE, PREAMBLE, PAYLOAD, CRC)
//   - CRC-32 constants (reflected polynomial, initial value)
//   - default preamble length
//   - crc32_step(): one-bit LSB-first CRC-32 update, shared by the serial
//     CRC engine and by the serializer's end-of-payload lookahead
package phy_tx_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_PAYLOAD  = 2'd2;
  localparam logic [1:0] ST_CRC      = 2'd3;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          CRC_BITS        = 32;

  localparam int DEFAULT_PREAMBLE_BITS = 16;

  // Reflected CRC-32: feedback is the register LSB xor the incoming bit.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return (crc >> 1) ^ (fb ? CRC32_POLY_REFL : 32'h0);
  endfunction

endpackage

// File: rtl/phy_tx_serializer_if.sv
// Interface between the protocol-layer transmitter and the PHY serializer.
//   msg_valid/msg_data/msg_ready : message handshake
//   tx_abort                     : discard the frame in progress
//   tx_data/tx_en                : registered serial line bit and driver enable
//   tx_done/tx_aborted           : one-cycle completion / abort pulses
//
// Handshake: a message is transferred on a rising clock edge where
// msg_valid and msg_ready are both high; msg_data must be stable while
// msg_valid is high. msg_ready is combinational and may drop without a
// transfer (e.g. when tx_abort is raised).
//
// Modports: master = protocol layer, slave = serializer.
interface phy_tx_serializer_if #(
  parameter int MSG_BITS = 32
);
  logic                msg_valid;
  logic [MSG_BITS-1:0] msg_data;
  logic                msg_ready;
  logic                tx_abort;
  logic                tx_data;
  logic                tx_en;
  logic                tx_done;
  logic                tx_aborted;

  modport master (
    output msg_valid, msg_data, tx_abort,
    input  msg_ready, tx_data, tx_en, tx_done, tx_aborted
  );

  modport slave (
    input  msg_valid, msg_data, tx_abort,
    output msg_ready, tx_data, tx_en, tx_done, tx_aborted
  );
endinterface

// File: rtl/phy_tx_serializer_crc32_serial.sv
// crc32_serial: bit-serial CRC-32 register (reflected, LSB-first).
// Shared with the receive path.
//   clk, reset_n : clock, asynchronous active-low reset (register -> init)
//   clear        : reload the initial value (wins over enable)
//   enable       : fold din into the register this cycle
//   din          : payload bit
//   crc          : current (uncomplemented) register value
module crc32_serial
  import phy_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        din,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC32_INIT;
    end else if (clear) begin
      crc <= CRC32_INIT;
    end else if (enable) begin
      crc <= crc32_step(crc, din);
    end
  end

endmodule

// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: turns one protocol-layer message into a line frame:
//   PREAMBLE_BITS alternating bits (0,1,...,1), MSG_BITS payload bits LSB
//   first, then the complemented CRC-32 of the payload, LSB first.
//   One line bit advances per bit_tick; without ticks the bit is held.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bit_tick     : one-cycle bit-rate enable
//   bus          : slave side of phy_tx_serializer_if (handshake + line)
//   dbg_state    : current FSM state (phy_tx_pkg ST_* encoding)
module phy_tx_serializer
  import phy_tx_pkg::*;
#(
  parameter int PREAMBLE_BITS = DEFAULT_PREAMBLE_BITS,
  parameter int MSG_BITS      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bit_tick,
  phy_tx_serializer_if.slave   bus,
  output logic [1:0]           dbg_state
);

  // Sized for the largest legal preamble so the counter never wraps.
  localparam int CNT_W = $clog2(64 + MSG_BITS + CRC_BITS + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_BITS - 1);

  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [MSG_BITS-1:0] msg_sr;     // bit 0 is the payload bit on the line
  logic [31:0]         crc_sr;     // bit 0 is the CRC bit on the line
  logic [31:0]         crc;
  logic [31:0]         crc_final;
  logic                accept;
  logic                crc_en;
  logic                tx_data_q;
  logic                tx_en_q;
  logic                tx_done_q;
  logic                tx_aborted_q;

  assign bus.msg_ready = (state == ST_IDLE) && !bus.tx_abort;
  assign accept        = bus.msg_valid && bus.msg_ready;
  assign crc_en        = (state == ST_PAYLOAD) && bit_tick && !bus.tx_abort;

  // CRC including the payload bit being shifted out this tick; used to
  // load the CRC shifter on the last payload tick without a bubble.
  assign crc_final = crc32_step(crc, msg_sr[0]);

  crc32_serial u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (crc_en),
    .din     (msg_sr[0]),
    .crc     (crc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      msg_sr       <= '0;
      crc_sr       <= '0;
      tx_data_q    <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_aborted_q <= 1'b0;
    end else begin
      tx_done_q    <= 1'b0;
      tx_aborted_q <= 1'b0;
      if ((state != ST_IDLE) && bus.tx_abort) begin
        // Abort outranks everything, including the final CRC tick.
        state        <= ST_IDLE;
        bit_cnt      <= '0;
        tx_en_q      <= 1'b0;
        tx_data_q    <= 1'b0;
        tx_aborted_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              state     <= ST_PREAMBLE;
              bit_cnt   <= '0;
              msg_sr    <= bus.msg_data;
              tx_en_q   <= 1'b1;
              tx_data_q <= 1'b0;
            end
          end
          ST_PREAMBLE: begin
            if (bit_tick) begin
              if (bit_cnt == PRE_LAST) begin
                state     <= ST_PAYLOAD;
                bit_cnt   <= '0;
                tx_data_q <= msg_sr[0];
              end else begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                // Preamble bit k is k[0]; the next one is the inverse of the current.
                tx_data_q <= ~bit_cnt[0];
              end
            end
          end
          ST_PAYLOAD: begin
            if (bit_tick) begin
              msg_sr <= msg_sr >> 1;
              if (bit_cnt == MSG_LAST) begin
                state     <= ST_CRC;
                bit_cnt   <= '0;
                crc_sr    <= ~crc_final;
                tx_data_q <= ~crc_final[0];
              end else begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                tx_data_q <= msg_sr[1];
              end
            end
          end
          ST_CRC: begin
            if (bit_tick) begin
              if (bit_cnt == CRC_LAST) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                tx_en_q   <= 1'b0;
                tx_data_q <= 1'b0;
                tx_done_q <= 1'b1;
              end else begin
                bit_cnt   <= bit_cnt + CNT_W'(1);
                crc_sr    <= crc_sr >> 1;
                tx_data_q <= crc_sr[1];
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_en      = tx_en_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.tx_aborted = tx_aborted_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Testbench for phy_tx_serializer: randomized messages and bit-tick
// patterns, checked against a byte-table CRC-32 model and a per-frame
// expected queue (preamble word, payload word, CRC word).
`timescale 1ns/1ps
module tb_phy_tx_serializer;
  import phy_tx_pkg::*;

  localparam int P     = 16;
  localparam int M     = 32;
  localparam int TOTAL = P + M + 32;
  localparam int W     = 64;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bit_tick = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  phy_tx_serializer_if #(.MSG_BITS(M)) bus ();

  phy_tx_serializer #(.PREAMBLE_BITS(P), .MSG_BITS(M)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_tick  (bit_tick),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int accept_cnt = 0;
  int exp_done = 0;
  int tick_div = 4;      // >0: every Nth cycle, 0: random, <0: none
  int cyc = 0;
  bit accept_pend = 1'b0;
  bit b2b_flag = 1'b0;

  logic [W-1:0] exp_q[$];
  logic         got_bits[$];
  logic [31:0]  crc_tbl[256];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic build_crc_table();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[n] = c;
    end
  endtask

  // Standard byte-wise CRC-32 of the message bytes, byte 0 = bits 7:0.
  function automatic logic [31:0] model_crc(input logic [M-1:0] d);
    logic [31:0] c;
    logic [7:0]  idx;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < M / 8; i++) begin
      idx = c[7:0] ^ d[i*8 +: 8];
      c = crc_tbl[idx] ^ (c >> 8);
    end
    return ~c;
  endfunction

  function automatic logic [W-1:0] model_pre();
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < P; k++) p[k] = (k % 2 == 1);
    return p;
  endfunction

  task automatic push_frame(input logic [M-1:0] d);
    exp_q.push_back(model_pre());
    exp_q.push_back(W'(d));
    exp_q.push_back(W'(model_crc(d)));
  endtask

  function automatic logic exp_bit(input int idx);
    if (idx < P) return exp_q[0][idx[5:0]];
    if (idx < P + M) return exp_q[1][6'(idx - P)];
    return exp_q[2][6'(idx - P - M)];
  endfunction

  // ---------------- tick generator ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (tick_div < 0) bit_tick = 1'b0;
      else if (tick_div == 0) bit_tick = ($urandom_range(0, 2) == 0);
      else bit_tick = (cyc % tick_div == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (accept_pend) begin
        chk("accept_tx_en", W'(bus.tx_en), W'(1));
        chk("accept_tx_data", W'(bus.tx_data), W'(0));
        accept_pend = 1'b0;
      end
      if (bus.tx_en && bit_tick) got_bits.push_back(bus.tx_data);
      if (bus.tx_done) begin
        logic [W-1:0] g_pre, g_pay, g_crc;
        done_cnt++;
        chk("done_tx_en", W'(bus.tx_en), W'(0));
        chk("done_tx_data", W'(bus.tx_data), W'(0));
        chk("frame_ticks", W'(got_bits.size()), W'(TOTAL));
        if (exp_q.size() < 3) begin
          chk("frame_expected", W'(exp_q.size()), W'(3));
        end else begin
          g_pre = '0; g_pay = '0; g_crc = '0;
          if (got_bits.size() == TOTAL) begin
            for (int i = 0; i < P; i++) g_pre[i] = got_bits[i];
            for (int i = 0; i < M; i++) g_pay[i] = got_bits[P + i];
            for (int i = 0; i < 32; i++) g_crc[i] = got_bits[P + M + i];
          end
          chk("preamble", g_pre, exp_q.pop_front());
          chk("payload", g_pay, exp_q.pop_front());
          chk("crc", g_crc, exp_q.pop_front());
        end
        got_bits.delete();
        if (bus.msg_valid && bus.msg_ready) b2b_flag = 1'b1;
      end
      if (bus.tx_aborted) begin
        abort_cnt++;
        chk("abort_tx_en", W'(bus.tx_en), W'(0));
        chk("abort_tx_data", W'(bus.tx_data), W'(0));
        got_bits.delete();
        repeat (3) if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (bus.msg_valid && bus.msg_ready) begin
        push_frame(bus.msg_data);
        accept_cnt++;
        accept_pend = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [M-1:0] d);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.msg_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    bus.msg_valid = 1'b1;
    bus.msg_data  = d;
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    bus.msg_data  = M'($urandom);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk); #1;
      if (!bus.msg_valid) bus.msg_data = M'($urandom);
      n++;
    end
    chk("done_within_budget", W'(done_cnt >= target), W'(1));
  endtask

  // Returns at posedge+2 once the bench has seen `target` line bits.
  task automatic wait_bits(input int target);
    int n = 0;
    while (got_bits.size() < target && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("bits_within_budget", W'(got_bits.size() >= target), W'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    int held;
    build_crc_table();
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    bus.tx_abort  = 1'b0;

    // Reset values.
    #12;
    chk("rst_tx_en", W'(bus.tx_en), W'(0));
    chk("rst_tx_data", W'(bus.tx_data), W'(0));
    chk("rst_tx_done", W'(bus.tx_done), W'(0));
    chk("rst_tx_aborted", W'(bus.tx_aborted), W'(0));
    chk("rst_state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", W'(bus.msg_ready), W'(1));

    chk("model_crc_zero", W'(model_crc('0)), W'(32'h2144DF1C));

    // All-zero message, tick every 4th cycle.
    tick_div = 4;
    send(32'h0000_0000);
    exp_done++;
    wait_done(exp_done);

    // Low byte set.
    send(32'h0000_00FF);
    exp_done++;
    wait_done(exp_done);

    // Random messages under several tick patterns (incl. tick every cycle).
    for (int i = 0; i < 4; i++) begin
      tick_div = i;
      send(M'($urandom));
      exp_done++;
      wait_done(exp_done);
    end

    // Stall ticks mid-payload: the line bit must be held.
    tick_div = 0;
    send(M'($urandom));
    wait_bits(P + 3);
    tick_div = -1;
    @(posedge clk); #2;
    held = got_bits.size();
    repeat (30) @(posedge clk);
    #2;
    chk("hold_bit", W'(bus.tx_data), W'(exp_bit(held)));
    chk("hold_count", W'(got_bits.size()), W'(held));
    tick_div = 0;
    exp_done++;
    wait_done(exp_done);

    // Abort at payload bit 10.
    tick_div = 2;
    send(M'($urandom));
    wait_bits(P + 10);
    bus.tx_abort = 1'b1;
    @(posedge clk); #1;
    bus.tx_abort = 1'b0;
    @(negedge clk); #1;
    chk("abort_pulse", W'(bus.tx_aborted), W'(1));
    chk("abort_line_en", W'(bus.tx_en), W'(0));
    chk("abort_no_done", W'(bus.tx_done), W'(0));
    chk("abort_ready", W'(bus.msg_ready), W'(1));
    chk("abort_state", W'(dbg_state), W'(ST_IDLE));
    @(negedge clk); #1;
    chk("abort_pulse_once", W'(bus.tx_aborted), W'(0));
    send(M'($urandom));
    exp_done++;
    wait_done(exp_done);

    // msg_valid together with tx_abort in IDLE: blocked, then accepted alone.
    base = accept_cnt;
    @(posedge clk); #1;
    bus.msg_valid = 1'b1;
    bus.tx_abort  = 1'b1;
    bus.msg_data  = M'($urandom);
    @(negedge clk); #1;
    chk("idle_abort_ready", W'(bus.msg_ready), W'(0));
    @(posedge clk); #1;
    bus.tx_abort = 1'b0;
    @(negedge clk); #1;
    chk("idle_abort_tx_en", W'(bus.tx_en), W'(0));
    chk("idle_abort_no_pulse", W'({bus.tx_done, bus.tx_aborted}), W'(0));
    @(posedge clk); #1;
    bus.msg_valid = 1'b0;
    chk("idle_abort_then_accept", W'(accept_cnt - base), W'(1));
    exp_done++;
    wait_done(exp_done);

    // Reset during CRC bit 5.
    tick_div = 3;
    send(M'($urandom));
    wait_bits(P + M + 5);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_en", W'(bus.tx_en), W'(0));
    chk("midrst_tx_data", W'(bus.tx_data), W'(0));
    chk("midrst_pulses", W'({bus.tx_done, bus.tx_aborted}), W'(0));
    chk("midrst_state", W'(dbg_state), W'(ST_IDLE));
    got_bits.delete();
    exp_q.delete();
    accept_pend = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_release_ready", W'(bus.msg_ready), W'(1));

    // Back-to-back frames with msg_valid held high and data churning.
    tick_div = 0;
    base = accept_cnt;
    b2b_flag = 1'b0;
    @(posedge clk); #1;
    bus.msg_valid = 1'b1;
    bus.msg_data  = M'($urandom);
    n = 0;
    while (accept_cnt < base + 2 && n < 3000) begin
      @(posedge clk); #1;
      bus.msg_data = M'($urandom);
      n++;
    end
    bus.msg_valid = 1'b0;
    exp_done += 2;
    wait_done(exp_done);
    chk("b2b_accept_in_done_cycle", W'(b2b_flag), W'(1));

    repeat (5) @(posedge clk);
    chk("done_count", W'(done_cnt), W'(exp_done));
    chk("abort_count", W'(abort_cnt), W'(1));
    chk("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
